uart_receiver_ext: RTL and testbench
====================================

Name: uart_receiver_ext

Overview:
Parametrised next-generation UART receiver: configurable data width, optional parity, 1 or 2 stop bits, and any oversampling ratio. Adds an input synchroniser, 3-sample majority-vote bit decisions, start-glitch rejection, and parity, framing and break error reporting. Sits between the pad-side i_rx line and the UART RX FIFO or ALU front-end. Consumes the shared baud-rate tick generator output.

Parameters:
NDATA_BITS, 8, data bits per frame; legal 5..9.
NSTOP_BITS, 1, stop bits; legal 1 or 2.
PARITY, 0, 0 = none, 1 = even, 2 = odd.
OVERSAMPLING, 16, i_baud ticks per bit period; legal >= 8, need not be a power of two.

Ports:
i_clock  in  1  system clock.
i_reset  in  1  synchronous active-high reset.
i_baud  in  1  one-clock enable pulse, OVERSAMPLING per bit period.
i_rx  in  1  asynchronous serial line, idle high.
o_data  out  NDATA_BITS  last received word, LSB first on the line.
o_rx_done  out  1  one-clock pulse when a frame completes.
o_parity_err  out  1  parity mismatch in the last frame.
o_frame_err  out  1  a stop bit of the last frame was sampled low.
o_break  out  1  last frame was a break.

Behaviour:
- One clock, i_clock. Reset is synchronous and active-high on i_reset.
- Reset: every output is 0, state is IDLE, and all counters and the synchroniser are set to 1/idle. Reset mid-frame aborts the frame with no o_rx_done.
- Synchroniser:
  - i_rx passes through 2 flops to give rx_s.
  - A third flop holds rx_d for edge detection.
- tick_cnt counts i_baud pulses from 0 to OVERSAMPLING-1 per bit period. It wraps to 0 and advances the bit on the tick where it equals OVERSAMPLING-1.
- Majority vote:
  - M = OVERSAMPLING/2 (integer division).
  - rx_s is sampled on i_baud ticks where tick_cnt = M-1, M and M+1.
  - The bit value is the majority of the 3 samples, decided on the M+1 tick.
- FSM states are IDLE, START, DATA, PARITY and STOP.
  - IDLE: on a falling edge (rx_d=1, rx_s=0), clear tick_cnt and go to START. A line held low never re-triggers, because an edge is required.
  - START: at the decision, majority 1 means a glitch, so return to IDLE with no output change. Majority 0 continues. At wrap, go to DATA with bit_cnt=0.
  - DATA: at each decision, shift the bit into a shift register, LSB first. At wrap, increment bit_cnt. After bit NDATA_BITS-1 wraps, go to PARITY if PARITY != 0, else go to STOP.
  - PARITY: at the decision, store par_bit. At wrap, go to STOP.
  - STOP: at each stop-bit decision, OR in (majority == 0) into an err accumulator.
    - For every stop bit except the last, continue at wrap.
    - On the last stop bit's decision, go directly to IDLE without waiting for the wrap. This lets the receiver catch a back-to-back start edge.
- Frame completion happens on the clock edge that registers the last stop decision. On that edge:
  - o_data is loaded from the shift register.
  - o_rx_done is 1 for exactly the following cycle.
  - Error flags are loaded.
- o_data and all flags hold until the next completion. They are not cleared by o_rx_done falling.
- Error flags:
  - o_parity_err = PARITY != 0 and (XOR of data bits XOR par_bit XOR (PARITY==2)) != 0.
  - o_frame_err = any stop bit sampled low.
  - o_break = shift register all zeros, par_bit (if present) 0, and first stop bit low. o_frame_err is also 1 in a break.
- Simultaneous events:
  - i_reset wins over everything.
  - A falling edge in IDLE in the same cycle as completion is not possible, because completion exits STOP into IDLE first. An edge on the next cycle is accepted.
- i_baud held low freezes the FSM. i_baud asserted every clock is legal.
- Frame length in i_baud ticks: (1 + NDATA_BITS + (PARITY!=0) + NSTOP_BITS - 1) × OVERSAMPLING + M + 2 from the edge to completion, plus a 2-3 clock synchroniser latency.

Test Plan:
- Defaults, 8N1, i_baud every 4 clocks, byte 0x55 → one o_rx_done pulse, o_data=0x55, all flags 0.
- PARITY=1, byte 0xA3 with parity bit 1 (correct is 0) → o_data=0xA3, o_parity_err=1. Repeat with parity bit 0 → o_parity_err=0.
- i_rx low for 3 ticks, then high → no o_rx_done, state returns to IDLE. A following valid 0x3C frame → o_data=0x3C.
- NSTOP_BITS=2, 0x81 with the second stop bit low → o_frame_err=1, o_break=0, o_data=0x81.
- Line held low for 2 frame times, then high, then frame 0x7E → first o_rx_done with o_data=0x00, o_break=1, o_frame_err=1. Exactly one pulse is produced while low. Then o_data=0x7E with flags 0.
- i_reset asserted for 1 clock at data bit 4 of 0xF0 → no o_rx_done, outputs 0. The next 0x0F frame is received correctly. Back-to-back frames 0x12, 0x34 with no idle gap → two pulses with the correct data.

Source files
------------

// File: rtl/uart_receiver_ext.sv
// Oversampled UART receiver with a two-flop input synchroniser, 3-sample majority
// bit decisions, start-glitch rejection and parity/framing/break error reporting.
module uart_receiver_ext #(
    parameter int NDATA_BITS   = 8,
    parameter int NSTOP_BITS   = 1,
    parameter int PARITY       = 0,
    parameter int OVERSAMPLING = 16
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_baud,
    input  logic                  i_rx,
    output logic [NDATA_BITS-1:0] o_data,
    output logic                  o_rx_done,
    output logic                  o_parity_err,
    output logic                  o_frame_err,
    output logic                  o_break
);

    localparam int M       = OVERSAMPLING / 2;
    localparam int TW      = $clog2(OVERSAMPLING);
    localparam bit HAS_PAR = (PARITY != 0);
    localparam bit ODD_PAR = (PARITY == 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR_BIT, STOP} state_t;

    state_t                state;
    logic                  rx_meta, rx_s, rx_d;
    logic [TW-1:0]         tick_cnt;
    logic [3:0]            bit_cnt;
    logic                  samp_a, samp_b;
    logic [NDATA_BITS-1:0] shreg;
    logic                  par_bit;
    logic                  err;
    logic                  stop1_low;

    logic maj, decide, wrap, last_stop, stop_err, first_low, par_mismatch, is_break;

    always_comb begin
        maj          = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
        decide       = i_baud && (tick_cnt == TW'(M + 1));
        wrap         = i_baud && (tick_cnt == TW'(OVERSAMPLING - 1));
        last_stop    = (bit_cnt == 4'(NSTOP_BITS - 1));
        stop_err     = err | ~maj;
        // The first stop bit may be the one being decided right now.
        first_low    = (bit_cnt == 4'd0) ? ~maj : stop1_low;
        par_mismatch = (^shreg) ^ par_bit ^ ODD_PAR;
        is_break     = (shreg == '0) && !(HAS_PAR && par_bit) && first_low;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state        <= IDLE;
            rx_meta      <= 1'b1;
            rx_s         <= 1'b1;
            rx_d         <= 1'b1;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            samp_a       <= 1'b1;
            samp_b       <= 1'b1;
            shreg        <= '0;
            par_bit      <= 1'b0;
            err          <= 1'b0;
            stop1_low    <= 1'b0;
            o_data       <= '0;
            o_rx_done    <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_break      <= 1'b0;
        end else begin
            rx_meta   <= i_rx;
            rx_s      <= rx_meta;
            rx_d      <= rx_s;
            o_rx_done <= 1'b0;
            if (state == IDLE) begin
                tick_cnt <= '0;
                if (rx_d && !rx_s) begin
                    state     <= START;
                    err       <= 1'b0;
                    stop1_low <= 1'b0;
                    par_bit   <= 1'b0;
                end
            end else if (i_baud) begin
                tick_cnt <= wrap ? '0 : tick_cnt + 1'b1;
                if (tick_cnt == TW'(M - 1)) samp_a <= rx_s;
                if (tick_cnt == TW'(M))     samp_b <= rx_s;
                case (state)
                    START: begin
                        if (decide && maj) begin
                            state    <= IDLE;
                            tick_cnt <= '0;
                        end else if (wrap) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        if (decide) shreg <= {maj, shreg[NDATA_BITS-1:1]};
                        if (wrap) begin
                            if (bit_cnt == 4'(NDATA_BITS - 1)) begin
                                bit_cnt <= '0;
                                state   <= HAS_PAR ? PAR_BIT : STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    PAR_BIT: begin
                        if (decide) par_bit <= maj;
                        if (wrap) begin
                            state   <= STOP;
                            bit_cnt <= '0;
                        end
                    end
                    STOP: begin
                        // Leave on the last decision so a back-to-back start edge is caught.
                        if (decide) begin
                            if (bit_cnt == 4'd0) stop1_low <= ~maj;
                            err <= stop_err;
                            if (last_stop) begin
                                state        <= IDLE;
                                tick_cnt     <= '0;
                                o_data       <= shreg;
                                o_rx_done    <= 1'b1;
                                o_parity_err <= HAS_PAR && par_mismatch;
                                o_frame_err  <= stop_err;
                                o_break      <= is_break;
                            end
                        end else if (wrap) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver_ext.sv
// Directed bench for uart_receiver_ext: three instances (8N1, 8E1, 8N2) share clock,
// reset and baud tick; each has its own serial line and a log of completed words.
module tb_uart_receiver_ext;

    localparam int BIT_CLKS = 64;

    logic       clock = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_baud = 1'b0;
    logic       rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
    logic [7:0] data_a, data_b, data_c;
    logic       done_a, done_b, done_c;
    logic       pe_a, pe_b, pe_c;
    logic       fe_a, fe_b, fe_c;
    logic       brk_a, brk_b, brk_c;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] log_a[$];
    logic [7:0] log_b[$];
    logic [7:0] log_c[$];

    uart_receiver_ext dut_a (
        .i_clock(clock), .i_reset(i_reset), .i_baud(i_baud), .i_rx(rx_a),
        .o_data(data_a), .o_rx_done(done_a), .o_parity_err(pe_a),
        .o_frame_err(fe_a), .o_break(brk_a)
    );

    uart_receiver_ext #(.PARITY(1)) dut_b (
        .i_clock(clock), .i_reset(i_reset), .i_baud(i_baud), .i_rx(rx_b),
        .o_data(data_b), .o_rx_done(done_b), .o_parity_err(pe_b),
        .o_frame_err(fe_b), .o_break(brk_b)
    );

    uart_receiver_ext #(.NSTOP_BITS(2)) dut_c (
        .i_clock(clock), .i_reset(i_reset), .i_baud(i_baud), .i_rx(rx_c),
        .o_data(data_c), .o_rx_done(done_c), .o_parity_err(pe_c),
        .o_frame_err(fe_c), .o_break(brk_c)
    );

    always #5 clock = ~clock;

    // Baud tick: one clock high out of every four, driven on the falling edge.
    initial begin
        int div;
        div = 0;
        forever begin
            @(negedge clock);
            div = (div + 1) % 4;
            i_baud = (div == 0);
        end
    end

    always @(negedge clock) begin
        if (done_a) log_a.push_back(data_a);
        if (done_b) log_b.push_back(data_b);
        if (done_c) log_c.push_back(data_c);
    end

    task automatic wait_clocks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_bit(input int which, input logic b);
        @(negedge clock);
        case (which)
            0: rx_a = b;
            1: rx_b = b;
            default: rx_c = b;
        endcase
        wait_clocks(BIT_CLKS - 1);
    endtask

    task automatic send_frame(input int which, input logic [7:0] d, input bit with_par,
                              input logic pbit, input int nstop, input logic s2);
        send_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(which, d[i]);
        if (with_par) send_bit(which, pbit);
        send_bit(which, 1'b1);
        if (nstop == 2) send_bit(which, s2);
    endtask

    task automatic test_reset();
        wait_clocks(5);
        @(negedge clock);
        i_reset = 1'b0;
        wait_clocks(3);
        vectors++;
        if (data_a !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_data: got %h expected 00", data_a); end
        vectors++;
        if ({done_a, pe_a, fe_a, brk_a} !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_flags_a: got %b expected 0000", {done_a, pe_a, fe_a, brk_a}); end
        vectors++;
        if ({done_b, pe_b, fe_b, brk_b, done_c, fe_c} !== 6'b0) begin miscompares++; $display("[TB] FAIL reset_flags_bc: got %b expected 000000", {done_b, pe_b, fe_b, brk_b, done_c, fe_c}); end
    endtask

    task automatic test_basic();
        int n0;
        n0 = log_a.size();
        send_frame(0, 8'h55, 1'b0, 1'b0, 1, 1'b1);
        send_bit(0, 1'b1);
        vectors++;
        if (log_a.size() - n0 !== 1) begin miscompares++; $display("[TB] FAIL basic_pulses: got %0d expected 1", log_a.size() - n0); end
        vectors++;
        if (data_a !== 8'h55) begin miscompares++; $display("[TB] FAIL basic_data: got %h expected 55", data_a); end
        vectors++;
        if ({pe_a, fe_a, brk_a} !== 3'b000) begin miscompares++; $display("[TB] FAIL basic_flags: got %b expected 000", {pe_a, fe_a, brk_a}); end
    endtask

    task automatic test_parity();
        send_frame(1, 8'hA3, 1'b1, 1'b1, 1, 1'b1);
        send_bit(1, 1'b1);
        vectors++;
        if (data_b !== 8'hA3) begin miscompares++; $display("[TB] FAIL parity_bad_data: got %h expected a3", data_b); end
        vectors++;
        if (pe_b !== 1'b1) begin miscompares++; $display("[TB] FAIL parity_bad_err: got %b expected 1", pe_b); end
        send_frame(1, 8'hA3, 1'b1, 1'b0, 1, 1'b1);
        send_bit(1, 1'b1);
        vectors++;
        if (pe_b !== 1'b0) begin miscompares++; $display("[TB] FAIL parity_good_err: got %b expected 0", pe_b); end
        vectors++;
        if ({fe_b, brk_b} !== 2'b00) begin miscompares++; $display("[TB] FAIL parity_good_flags: got %b expected 00", {fe_b, brk_b}); end
        vectors++;
        if (log_b.size() !== 2) begin miscompares++; $display("[TB] FAIL parity_pulses: got %0d expected 2", log_b.size()); end
    endtask

    task automatic test_glitch();
        int n0;
        n0 = log_a.size();
        @(negedge clock);
        rx_a = 1'b0;
        wait_clocks(12);
        rx_a = 1'b1;
        wait_clocks(12 * BIT_CLKS);
        vectors++;
        if (log_a.size() - n0 !== 0) begin miscompares++; $display("[TB] FAIL glitch_pulses: got %0d expected 0", log_a.size() - n0); end
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1, 1'b1);
        send_bit(0, 1'b1);
        vectors++;
        if (data_a !== 8'h3C) begin miscompares++; $display("[TB] FAIL glitch_next_data: got %h expected 3c", data_a); end
        vectors++;
        if (log_a.size() - n0 !== 1) begin miscompares++; $display("[TB] FAIL glitch_next_pulses: got %0d expected 1", log_a.size() - n0); end
    endtask

    task automatic test_frame_err();
        send_frame(2, 8'h81, 1'b0, 1'b0, 2, 1'b0);
        send_bit(2, 1'b1);
        send_bit(2, 1'b1);
        vectors++;
        if (data_c !== 8'h81) begin miscompares++; $display("[TB] FAIL frame_data: got %h expected 81", data_c); end
        vectors++;
        if ({fe_c, brk_c} !== 2'b10) begin miscompares++; $display("[TB] FAIL frame_flags: got %b expected 10", {fe_c, brk_c}); end
        vectors++;
        if (log_c.size() !== 1) begin miscompares++; $display("[TB] FAIL frame_pulses: got %0d expected 1", log_c.size()); end
    endtask

    task automatic test_break();
        int n0;
        n0 = log_a.size();
        @(negedge clock);
        rx_a = 1'b0;
        wait_clocks(20 * BIT_CLKS);
        rx_a = 1'b1;
        wait_clocks(3 * BIT_CLKS);
        vectors++;
        if (log_a.size() - n0 !== 1) begin miscompares++; $display("[TB] FAIL break_pulses: got %0d expected 1", log_a.size() - n0); end
        vectors++;
        if (data_a !== 8'h00) begin miscompares++; $display("[TB] FAIL break_data: got %h expected 00", data_a); end
        vectors++;
        if ({pe_a, fe_a, brk_a} !== 3'b011) begin miscompares++; $display("[TB] FAIL break_flags: got %b expected 011", {pe_a, fe_a, brk_a}); end
        send_frame(0, 8'h7E, 1'b0, 1'b0, 1, 1'b1);
        send_bit(0, 1'b1);
        vectors++;
        if (data_a !== 8'h7E) begin miscompares++; $display("[TB] FAIL break_next_data: got %h expected 7e", data_a); end
        vectors++;
        if ({pe_a, fe_a, brk_a} !== 3'b000) begin miscompares++; $display("[TB] FAIL break_next_flags: got %b expected 000", {pe_a, fe_a, brk_a}); end
    endtask

    task automatic test_reset_mid_frame();
        int n0;
        logic [7:0] d;
        d = 8'hF0;
        n0 = log_a.size();
        send_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(0, d[i]);
        @(negedge clock);
        rx_a = d[4];
        wait_clocks(BIT_CLKS / 2);
        i_reset = 1'b1;
        @(negedge clock);
        i_reset = 1'b0;
        wait_clocks(BIT_CLKS / 2 - 2);
        for (int i = 5; i < 8; i++) send_bit(0, d[i]);
        send_bit(0, 1'b1);
        send_bit(0, 1'b1);
        vectors++;
        if (log_a.size() - n0 !== 0) begin miscompares++; $display("[TB] FAIL midreset_pulses: got %0d expected 0", log_a.size() - n0); end
        vectors++;
        if ({data_a, pe_a, fe_a, brk_a} !== 11'b0) begin miscompares++; $display("[TB] FAIL midreset_outputs: got %h expected 000", {data_a, pe_a, fe_a, brk_a}); end
        send_frame(0, 8'h0F, 1'b0, 1'b0, 1, 1'b1);
        send_bit(0, 1'b1);
        vectors++;
        if (data_a !== 8'h0F) begin miscompares++; $display("[TB] FAIL midreset_next_data: got %h expected 0f", data_a); end
    endtask

    task automatic test_back_to_back();
        int n0;
        n0 = log_a.size();
        send_frame(0, 8'h12, 1'b0, 1'b0, 1, 1'b1);
        send_frame(0, 8'h34, 1'b0, 1'b0, 1, 1'b1);
        send_bit(0, 1'b1);
        vectors++;
        if (log_a.size() - n0 !== 2) begin
            miscompares++;
            $display("[TB] FAIL b2b_pulses: got %0d expected 2", log_a.size() - n0);
        end else begin
            vectors++;
            if (log_a[n0] !== 8'h12) begin miscompares++; $display("[TB] FAIL b2b_first: got %h expected 12", log_a[n0]); end
            vectors++;
            if (log_a[n0+1] !== 8'h34) begin miscompares++; $display("[TB] FAIL b2b_second: got %h expected 34", log_a[n0+1]); end
        end
        vectors++;
        if ({fe_a, brk_a} !== 2'b00) begin miscompares++; $display("[TB] FAIL b2b_flags: got %b expected 00", {fe_a, brk_a}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_glitch();
        test_frame_err();
        test_break();
        test_reset_mid_frame();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
